text_screen_buffer: RTL and testbench

Character-cell screen memory that sits directly downstream of the on-screen text printers (target tracker, status printers). It accepts `char_index`/`char_data` writes through a small queue and commits one per cycle into a 256-cell character RAM. It clears the screen to blank on reset or on command, and serves a one-cycle-latency read port to the VGA glyph renderer.

---
 rtl/text_screen_buffer_if.sv | 27 ++
 rtl/text_screen_buffer.sv | 97 +++++++++
 tb/tb_text_screen_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_screen_buffer_if.sv
// Printer/renderer-facing bundle of the text screen buffer:
// queued cell writes, clear control and the renderer read port.
interface text_screen_buffer_if #(
  parameter int CELLS_LOG2 = 8
);
  logic                  wr_en;
  logic [CELLS_LOG2-1:0] char_index;
  logic [7:0]            char_data;
  logic                  wr_ready;
  logic                  clear;
  logic                  busy;
  logic                  overflow;
  logic [CELLS_LOG2-1:0] rd_index;
  logic [7:0]            rd_data;

  modport master (
    output wr_en, char_index, char_data,
    output clear, rd_index,
    input  wr_ready, busy, overflow, rd_data
  );

  modport slave (
    input  wr_en, char_index, char_data,
    input  clear, rd_index,
    output wr_ready, busy, overflow, rd_data
  );
endinterface

// File: rtl/text_screen_buffer.sv
// Character-cell screen RAM with a small write queue, a blanking
// sweep on reset/clear, and a one-cycle read-first renderer port.
module text_screen_buffer #(
  parameter int         CELLS_LOG2 = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input logic clock,
  input logic resetn,
  text_screen_buffer_if.slave bus
);

  localparam int QW    = $clog2(FIFO_DEPTH);
  localparam int CELLS = 1 << CELLS_LOG2;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [CELLS_LOG2-1:0] idx;
    logic [7:0]            data;
  } entry_t;

  state_t                state;
  logic [CELLS_LOG2-1:0] clr_ptr;
  logic [QW-1:0]         wptr;
  logic [QW-1:0]         rptr;
  logic [QW:0]           count;
  logic [QW:0]           count_nxt;
  logic                  push;
  logic                  pop;
  entry_t                q [FIFO_DEPTH];
  logic [7:0]            ram [CELLS];

  assign push = bus.wr_en && bus.wr_ready;
  // A clear request in IDLE wins over the pop so queued text lands after the sweep.
  assign pop  = (state == IDLE) && !bus.clear
             && (count != '0);

  always_comb begin
    count_nxt = count;
    count_nxt = count_nxt + (QW+1)'(push);
    count_nxt = count_nxt - (QW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR)
      ram[clr_ptr] <= BLANK_CHAR;
    else if (pop)
      ram[q[rptr].idx] <= q[rptr].data;
    if (push)
      q[wptr] <= '{idx: bus.char_index,
                   data: bus.char_data};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= CLEAR;
      clr_ptr      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.busy     <= 1'b1;
      bus.wr_ready <= 1'b1;
      bus.overflow <= 1'b0;
      bus.rd_data  <= 8'h00;
    end else begin
      bus.rd_data  <= ram[bus.rd_index];
      count        <= count_nxt;
      bus.wr_ready <= count_nxt != (QW+1)'(FIFO_DEPTH);
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.clear) begin
            state        <= CLEAR;
            bus.busy     <= 1'b1;
            bus.overflow <= 1'b0;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // A write dropped on the same edge as a clear still leaves its mark.
      if (bus.wr_en && !bus.wr_ready)
        bus.overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed bench for text_screen_buffer with a write scoreboard
// and a reference copy of the screen contents.
module tb_text_screen_buffer;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t        sb [$];
  logic [7:0] model [256];

  text_screen_buffer_if bus ();

  text_screen_buffer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic blank_model();
    for (int i = 0; i < 256; i++)
      model[i] = 8'h20;
  endtask

  // Counts edges until busy drops; a bound expiry is a failure.
  task automatic wait_idle(input string tag,
                           input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.busy && n < 2000);
    chk(tag, n, exp_n);
  endtask

  task automatic rd(input logic [7:0] idx,
                    output logic [7:0] val);
    bus.rd_index = idx;
    step();
    val = bus.rd_data;
  endtask

  task automatic drain_sb(input string tag);
    wr_t        e;
    logic [7:0] v;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.idx, v);
      chk(tag, v, e.data);
    end
  endtask

  task automatic push_wr(input logic [7:0] idx,
                         input logic [7:0] data);
    bus.wr_en      = 1'b1;
    bus.char_index = idx;
    bus.char_data  = data;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] idx;
    logic [7:0] dat;
    int         errs;
    bus.wr_en      = 1'b0;
    bus.char_index = '0;
    bus.char_data  = '0;
    bus.clear      = 1'b0;
    bus.rd_index   = '0;
    blank_model();

    // reset state
    #23;
    chk("rst_busy", bus.busy, 1);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    resetn = 1'b1;
    wait_idle("rst_sweep_len", 256);
    rd(8'd0, v);   chk("blank_0", v, 8'h20);
    rd(8'd116, v); chk("blank_116", v, 8'h20);
    rd(8'd255, v); chk("blank_255", v, 8'h20);

    // single write latency
    bus.rd_index = 8'd176;
    push_wr(8'd176, 8'h37);
    step();
    bus.wr_en = 1'b0;
    step();
    chk("single_n1", bus.rd_data, 8'h20);
    step();
    chk("single_n2", bus.rd_data, 8'h37);
    model[176] = 8'h37;

    // back-to-back tracker-style burst
    for (int i = 0; i < 32; i++) begin
      idx = (i < 20) ? 8'(176 + i * 3)
                     : 8'(116 + i - 20);
      dat = ((i % 16) < 10) ? 8'(8'h30 + i % 16)
                            : 8'(8'h41 + i % 16 - 10);
      push_wr(idx, dat);
      sb.push_back('{idx: idx, data: dat});
      model[idx] = dat;
      step();
      chk("burst_ready", bus.wr_ready, 1);
    end
    bus.wr_en = 1'b0;
    chk("burst_ovf", bus.overflow, 0);
    step();
    step();
    drain_sb("burst_rd");

    // overflow while sweeping
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_busy", bus.busy, 1);
    blank_model();
    for (int i = 0; i < 5; i++) begin
      push_wr(8'(1 + i), 8'(8'h61 + i));
      if (i < 4) begin
        sb.push_back('{idx: 8'(1 + i),
                       data: 8'(8'h61 + i)});
        model[1 + i] = 8'(8'h61 + i);
      end
      step();
      if (i == 3) begin
        chk("ovf_ready4", bus.wr_ready, 0);
        chk("ovf_flag4", bus.overflow, 0);
      end
    end
    bus.wr_en = 1'b0;
    chk("ovf_flag5", bus.overflow, 1);
    chk("ovf_ready5", bus.wr_ready, 0);
    wait_idle("ovf_sweep_len", 251);
    repeat (5) step();
    chk("ovf_ready_after", bus.wr_ready, 1);
    drain_sb("ovf_rd");
    rd(8'd5, v);   chk("ovf_dropped", v, 8'h20);
    rd(8'd176, v); chk("ovf_cleared", v, 8'h20);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("ovf_cleared_flag", bus.overflow, 0);
    wait_idle("clr2_sweep_len", 256);
    blank_model();

    // clear and write on the same edge
    bus.clear = 1'b1;
    push_wr(8'd10, 8'h41);
    step();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    model[10] = 8'h41;
    wait_idle("sim_sweep_len", 256);
    step();
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      rd(8'(i), v);
      if (v !== model[i]) errs++;
    end
    chk("sim_screen_errs", errs, 0);
    rd(8'd10, v); chk("sim_cell10", v, 8'h41);

    // reset in the middle of a sweep
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_wr(8'(200 + i), 8'h55);
      step();
    end
    bus.wr_en = 1'b0;
    repeat (94) step();
    chk("mid_busy", bus.busy, 1);
    chk("mid_ovf_set", bus.overflow, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready", bus.wr_ready, 1);
    chk("mid_rst_ovf", bus.overflow, 0);
    chk("mid_rst_rd", bus.rd_data, 8'h00);
    chk("mid_rst_busy", bus.busy, 1);
    repeat (2) @(posedge clock);
    #4;
    resetn = 1'b1;
    wait_idle("mid_sweep_len", 256);
    step();
    rd(8'd200, v); chk("mid_q_emptied", v, 8'h20);
    rd(8'd203, v); chk("mid_q_emptied3", v, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
